// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register.
// Captures the decode-stage fields on the falling edge of CLK and applies one
// action per edge in priority order: reset, flush, stall, load. Control
// fields are cleared whenever a bubble enters: on a flush, or on a load of an
// invalid instruction. The stage also flags load-use hazards against the
// current decode-stage source registers. Two saturating counters record
// stall and bubble activity.
module id_ex_pipe #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               cnt_clr_i,
  input  logic               valid_i,
  input  logic [RADDR_W-1:0] Rreg_addr1_i,
  input  logic [RADDR_W-1:0] Rreg_addr2_i,
  input  logic [RADDR_W-1:0] Wreg_addr_i,
  input  logic [DATA_W-1:0]  imm_i,
  input  logic [DATA_W-1:0]  Rdata1_i,
  input  logic [DATA_W-1:0]  Rdata2_i,
  input  logic [DATA_W-1:0]  next_PC_i,
  input  logic               JtoPC_i,
  input  logic               Branch_i,
  input  logic               RegWrite_i,
  input  logic               ALUSrc_i,
  input  logic               MemWrite_i,
  input  logic               MemRead_i,
  input  logic               MemtoReg_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  output logic               valid_o,
  output logic [RADDR_W-1:0] Rreg_addr1_o,
  output logic [RADDR_W-1:0] Rreg_addr2_o,
  output logic [RADDR_W-1:0] Wreg_addr_o,
  output logic [DATA_W-1:0]  imm_o,
  output logic [DATA_W-1:0]  Rdata1_o,
  output logic [DATA_W-1:0]  Rdata2_o,
  output logic [DATA_W-1:0]  next_PC_o,
  output logic               JtoPC_o,
  output logic               Branch_o,
  output logic               RegWrite_o,
  output logic               ALUSrc_o,
  output logic               MemWrite_o,
  output logic               MemRead_o,
  output logic               MemtoReg_o,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic               load_use_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  // Control bits kept as one vector: {JtoPC, Branch, RegWrite, ALUSrc,
  // MemWrite, MemRead, MemtoReg}.
  localparam int CTRL_W = 7;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CTRL_W-1:0]  ctrl_in;
  logic               valid_q, valid_d;
  logic [RADDR_W-1:0] ra1_q, ra1_d, ra2_q, ra2_d, wa_q, wa_d;
  logic [DATA_W-1:0]  imm_q, imm_d, rd1_q, rd1_d, rd2_q, rd2_d, npc_q, npc_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [ALUOP_W-1:0] aluop_q, aluop_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;

  assign ctrl_in = {JtoPC_i, Branch_i, RegWrite_i, ALUSrc_i,
                    MemWrite_i, MemRead_i, MemtoReg_i};

  // Next stage contents: flush beats stall, stall holds, otherwise load.
  always_comb begin
    valid_d = valid_q;
    ra1_d   = ra1_q;
    ra2_d   = ra2_q;
    wa_d    = wa_q;
    imm_d   = imm_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    npc_d   = npc_q;
    ctrl_d  = ctrl_q;
    aluop_d = aluop_q;
    if (flush_i || !stall_i) begin
      // Datapath fields follow the inputs even on a bubble so the stage
      // never carries stale data.
      ra1_d = Rreg_addr1_i;
      ra2_d = Rreg_addr2_i;
      wa_d  = Wreg_addr_i;
      imm_d = imm_i;
      rd1_d = Rdata1_i;
      rd2_d = Rdata2_i;
      npc_d = next_PC_i;
      if (flush_i || !valid_i) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
        aluop_d = '0;
      end else begin
        valid_d = 1'b1;
        ctrl_d  = ctrl_in;
        aluop_d = ALUOp_i;
      end
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (cnt_clr_i) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (stall_i && !flush_i && valid_q && (stall_cnt_q != CNT_MAX))
        stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush_i && (bubble_cnt_q != CNT_MAX))
        bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  // Stage register, updated on the falling edge with synchronous reset.
  always_ff @(negedge CLK) begin
    if (!RSTn) begin
      valid_q      <= 1'b0;
      ra1_q        <= '0;
      ra2_q        <= '0;
      wa_q         <= '0;
      imm_q        <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      npc_q        <= '0;
      ctrl_q       <= '0;
      aluop_q      <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      ra1_q        <= ra1_d;
      ra2_q        <= ra2_d;
      wa_q         <= wa_d;
      imm_q        <= imm_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      npc_q        <= npc_d;
      ctrl_q       <= ctrl_d;
      aluop_q      <= aluop_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign valid_o      = valid_q;
  assign Rreg_addr1_o = ra1_q;
  assign Rreg_addr2_o = ra2_q;
  assign Wreg_addr_o  = wa_q;
  assign imm_o        = imm_q;
  assign Rdata1_o     = rd1_q;
  assign Rdata2_o     = rd2_q;
  assign next_PC_o    = npc_q;
  assign JtoPC_o      = ctrl_q[6];
  assign Branch_o     = ctrl_q[5];
  assign RegWrite_o   = ctrl_q[4];
  assign ALUSrc_o     = ctrl_q[3];
  assign MemWrite_o   = ctrl_q[2];
  assign MemRead_o    = ctrl_q[1];
  assign MemtoReg_o   = ctrl_q[0];
  assign ALUOp_o      = aluop_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;

  // Register 0 is never a real producer, so it cannot create a hazard.
  assign load_use_o = valid_q && ctrl_q[1] && (wa_q != '0) &&
                      ((wa_q == Rreg_addr1_i) || (wa_q == Rreg_addr2_i));

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: table of vectors with hand-derived valid/counter
// expectations, a reference model feeding a scoreboard queue for the full
// stage contents, and directed sequences for load-use, saturation, clear and
// reset-during-stall.
module tb_id_ex_pipe;

  typedef struct packed {
    logic        valid;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa;
    logic [31:0] imm;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] npc;
    logic [6:0]  ctrl;   // {J, Br, RegW, ALUSrc, MemW, MemR, MemtoReg}
    logic [3:0]  aluop;
  } pipe_t;

  typedef struct packed {
    pipe_t      f;
    logic [3:0] sc;
    logic [3:0] bc;
    logic       lu;
  } exp_t;

  typedef struct {
    logic       rst_n;
    logic       stall;
    logic       flush;
    logic       clr;
    pipe_t      in;
    logic       exp_valid;
    logic [3:0] exp_sc;
    logic [3:0] exp_bc;
  } vec_t;

  logic CLK;
  logic rstn_s, stall_s, flush_s, clr_s;
  pipe_t in_s, out_s;
  logic [3:0] sc_o, bc_o;
  logic lu_o;

  logic v_o, j_o, br_o, rw_o, as_o, mw_o, mr_o, m2r_o;
  logic [4:0] ra1_o, ra2_o, wa_o;
  logic [31:0] imm_o, rd1_o, rd2_o, npc_o;
  logic [3:0] aluop_o;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_t m;
  logic [3:0] m_sc, m_bc;
  exp_t sb[$];

  id_ex_pipe #(.DATA_W(32), .RADDR_W(5), .ALUOP_W(4), .CNT_W(4)) dut (
    .CLK(CLK), .RSTn(rstn_s), .stall_i(stall_s), .flush_i(flush_s),
    .cnt_clr_i(clr_s), .valid_i(in_s.valid),
    .Rreg_addr1_i(in_s.ra1), .Rreg_addr2_i(in_s.ra2), .Wreg_addr_i(in_s.wa),
    .imm_i(in_s.imm), .Rdata1_i(in_s.rd1), .Rdata2_i(in_s.rd2),
    .next_PC_i(in_s.npc),
    .JtoPC_i(in_s.ctrl[6]), .Branch_i(in_s.ctrl[5]), .RegWrite_i(in_s.ctrl[4]),
    .ALUSrc_i(in_s.ctrl[3]), .MemWrite_i(in_s.ctrl[2]), .MemRead_i(in_s.ctrl[1]),
    .MemtoReg_i(in_s.ctrl[0]), .ALUOp_i(in_s.aluop),
    .valid_o(v_o), .Rreg_addr1_o(ra1_o), .Rreg_addr2_o(ra2_o), .Wreg_addr_o(wa_o),
    .imm_o(imm_o), .Rdata1_o(rd1_o), .Rdata2_o(rd2_o), .next_PC_o(npc_o),
    .JtoPC_o(j_o), .Branch_o(br_o), .RegWrite_o(rw_o), .ALUSrc_o(as_o),
    .MemWrite_o(mw_o), .MemRead_o(mr_o), .MemtoReg_o(m2r_o), .ALUOp_o(aluop_o),
    .load_use_o(lu_o), .stall_cnt_o(sc_o), .bubble_cnt_o(bc_o)
  );

  always_comb out_s = {v_o, ra1_o, ra2_o, wa_o, imm_o, rd1_o, rd2_o, npc_o,
                       j_o, br_o, rw_o, as_o, mw_o, mr_o, m2r_o, aluop_o};

  initial begin
    CLK = 1'b1;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout, got no summary, required finish");
    $fatal(1, "timeout");
  end

  function automatic pipe_t mk(logic v, logic [4:0] a1, logic [4:0] a2,
                               logic [4:0] w, logic [31:0] im, logic [31:0] d1,
                               logic [31:0] d2, logic [31:0] pc,
                               logic [6:0] c, logic [3:0] op);
    pipe_t p;
    p = '{valid: v, ra1: a1, ra2: a2, wa: w, imm: im, rd1: d1, rd2: d2,
          npc: pc, ctrl: c, aluop: op};
    return p;
  endfunction

  task automatic chk(input string name, input logic [159:0] act,
                     input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic model_lu(pipe_t st, pipe_t in);
    return st.valid && st.ctrl[1] && (st.wa != 5'd0) &&
           ((st.wa == in.ra1) || (st.wa == in.ra2));
  endfunction

  // Drive one edge worth of stimulus, predict, then compare after the edge.
  task automatic step(input logic rst_n, input logic stall, input logic flush,
                      input logic clr, input pipe_t in);
    exp_t e;
    exp_t got;
    rstn_s  = rst_n;
    stall_s = stall;
    flush_s = flush;
    clr_s   = clr;
    in_s    = in;
    if (!rst_n) begin
      m = '0; m_sc = '0; m_bc = '0;
    end else begin
      if (clr) begin
        m_sc = '0; m_bc = '0;
      end else begin
        if (stall && !flush && m.valid && m_sc != 4'hF) m_sc = m_sc + 4'd1;
        if (flush && m_bc != 4'hF) m_bc = m_bc + 4'd1;
      end
      if (flush) begin
        m = in;
        m.valid = 1'b0; m.ctrl = '0; m.aluop = '0;
      end else if (!stall) begin
        m = in;
        if (!in.valid) begin
          m.ctrl = '0; m.aluop = '0;
        end
      end
    end
    e.f = m; e.sc = m_sc; e.bc = m_bc; e.lu = model_lu(m, in);
    sb.push_back(e);
    @(negedge CLK);
    #1;
    got = sb.pop_front();
    chk("fields", 160'(out_s), 160'(got.f));
    chk("stall_cnt", 160'(sc_o), 160'(got.sc));
    chk("bubble_cnt", 160'(bc_o), 160'(got.bc));
    chk("load_use", 160'(lu_o), 160'(got.lu));
  endtask

  vec_t tbl[10];
  pipe_t z;

  initial begin
    z = '0;
    m = '0; m_sc = '0; m_bc = '0;
    rstn_s = 1'b0; stall_s = 1'b0; flush_s = 1'b0; clr_s = 1'b0; in_s = '0;

    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b1, mk(1, 1, 2, 3, 32'h11, 32'h22, 32'h33, 32'h44, 7'h7F, 4'hF), 1'b0, 4'd0, 4'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 32'h0, 32'h1234_5678, 32'h0, 32'h0, 7'b0010000, 4'h2), 1'b1, 4'd0, 4'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, mk(1, 4, 5, 6, 32'hA1, 32'hB1, 32'hC1, 32'hD1, 7'h55, 4'h7), 1'b1, 4'd1, 4'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, mk(1, 7, 8, 9, 32'hA2, 32'hB2, 32'hC2, 32'hD2, 7'h2A, 4'h8), 1'b1, 4'd2, 4'd0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, mk(1, 10, 11, 12, 32'hA3, 32'hB3, 32'hC3, 32'hD3, 7'h7F, 4'h9), 1'b1, 4'd3, 4'd0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, mk(1, 13, 14, 15, 32'hA4, 32'hB4, 32'hC4, 32'hD4, 7'h7F, 4'hA), 1'b0, 4'd3, 4'd1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(0, 16, 17, 18, 32'hCAFE, 32'hBEEF, 32'hF00D, 32'h400, 7'h7F, 4'hF), 1'b0, 4'd3, 4'd1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(1, 1, 2, 8, 32'h5, 32'h6, 32'h7, 32'h8, 7'b0000010, 4'h0), 1'b1, 4'd3, 4'd1};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 32'h9, 32'hA, 32'hB, 32'hC, 7'b0000010, 4'h1), 1'b1, 4'd3, 4'd1};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b1, mk(1, 3, 3, 3, 32'hD, 32'hE, 32'hF, 32'h10, 7'h01, 4'h3), 1'b1, 4'd0, 4'd0};

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst_n, tbl[i].stall, tbl[i].flush, tbl[i].clr, tbl[i].in);
      chk($sformatf("vec%0d_valid", i), 160'(v_o), 160'(tbl[i].exp_valid));
      chk($sformatf("vec%0d_stall_cnt", i), 160'(sc_o), 160'(tbl[i].exp_sc));
      chk($sformatf("vec%0d_bubble_cnt", i), 160'(bc_o), 160'(tbl[i].exp_bc));
      if (i == 1) begin
        chk("load_rdata1", 160'(rd1_o), 160'(32'h1234_5678));
        chk("load_aluop", 160'(aluop_o), 160'(4'h2));
        chk("load_regwrite", 160'(rw_o), 160'(1'b1));
      end
      if (i == 4) chk("stall_hold_rdata1", 160'(rd1_o), 160'(32'h1234_5678));
      if (i == 5) chk("flush_ctrl_zero", 160'({j_o, br_o, rw_o, as_o, mw_o, mr_o, m2r_o, aluop_o}), 160'(0));
      if (i == 6) begin
        chk("gate_ctrl_zero", 160'({j_o, br_o, rw_o, as_o, mw_o, mr_o, m2r_o, aluop_o}), 160'(0));
        chk("gate_imm", 160'(imm_o), 160'(32'hCAFE));
        chk("gate_rdata2", 160'(rd2_o), 160'(32'hF00D));
      end
    end

    // Load-use against either source, and the non-hazard cases.
    step(1, 0, 0, 0, mk(1, 3, 4, 8, 0, 0, 0, 0, 7'b0000010, 4'h0));
    in_s.ra2 = 5'd8; #1;
    chk("lu_src2", 160'(lu_o), 160'(1'b1));
    in_s.ra2 = 5'd4; in_s.ra1 = 5'd8; #1;
    chk("lu_src1", 160'(lu_o), 160'(1'b1));
    in_s.ra1 = 5'd9; #1;
    chk("lu_nomatch", 160'(lu_o), 160'(1'b0));
    step(1, 0, 0, 0, mk(1, 3, 4, 0, 0, 0, 0, 0, 7'b0000010, 4'h0));
    in_s.ra2 = 5'd8; #1;
    chk("lu_wa_zero", 160'(lu_o), 160'(1'b0));
    step(1, 0, 0, 0, mk(1, 8, 8, 8, 0, 0, 0, 0, 7'b0010000, 4'h0));
    chk("lu_not_load", 160'(lu_o), 160'(1'b0));

    // Saturation of both counters, then clear during a stall.
    step(1, 0, 0, 0, mk(1, 1, 1, 1, 32'h1, 32'h2, 32'h3, 32'h4, 7'h10, 4'h1));
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, mk(1, 5, 5, 5, 32'h9, 32'h9, 32'h9, 32'h9, 7'h7F, 4'hF));
    chk("stall_sat", 160'(sc_o), 160'(4'd15));
    chk("stall_sat_hold", 160'(rd1_o), 160'(32'h2));
    step(1, 1, 0, 1, z);
    chk("stall_clr", 160'(sc_o), 160'(4'd0));
    for (int i = 0; i < 20; i++) step(1, 0, 1, 0, mk(1, 2, 2, 2, i, i, i, i, 7'h7F, 4'h5));
    chk("bubble_sat", 160'(bc_o), 160'(4'd15));

    // Reset in the middle of a stall discards the held instruction.
    step(1, 0, 0, 0, mk(1, 6, 7, 8, 32'h77, 32'h88, 32'h99, 32'hAA, 7'h12, 4'h6));
    step(1, 1, 0, 0, mk(1, 9, 9, 9, 32'h1, 32'h1, 32'h1, 32'h1, 7'h7F, 4'hF));
    step(0, 1, 1, 1, mk(1, 9, 9, 9, 32'h1, 32'h1, 32'h1, 32'h1, 7'h7F, 4'hF));
    chk("rst_fields", 160'(out_s), 160'(0));
    chk("rst_counts", 160'({sc_o, bc_o}), 160'(0));
    step(1, 1, 0, 0, mk(1, 9, 9, 9, 32'h1, 32'h1, 32'h1, 32'h1, 7'h7F, 4'hF));
    chk("rst_release_fields", 160'(out_s), 160'(0));
    chk("rst_release_stall_cnt", 160'(sc_o), 160'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of the register-data, immediate and next-PC fields.
REQ-002 The block SHALL have parameter RADDR_W, default 5, meaning the width of each register-address field.
REQ-003 The block SHALL have parameter ALUOP_W, default 4, meaning the width of the ALU opcode field.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning the width of each performance counter.
REQ-005 The block SHALL have port CLK, input, 1 bit: the single clock. Registers update on the falling edge of CLK, per codebase pipeline-register convention.
REQ-006 The block SHALL have port RSTn, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port stall_i, input, 1 bit: hold the current stage contents.
REQ-008 The block SHALL have port flush_i, input, 1 bit: insert a bubble.
REQ-009 The block SHALL have port cnt_clr_i, input, 1 bit: clear both performance counters.
REQ-010 The block SHALL have port valid_i, input, 1 bit: the decode-stage instruction is valid.
REQ-011 The block SHALL have ports Rreg_addr1_i and Rreg_addr2_i, input, RADDR_W bits each: the source register addresses.
REQ-012 The block SHALL have port Wreg_addr_i, input, RADDR_W bits: the destination register address.
REQ-013 The block SHALL have ports imm_i, Rdata1_i, Rdata2_i and next_PC_i, input, DATA_W bits each: the datapath fields.
REQ-014 The block SHALL have ports JtoPC_i, Branch_i, RegWrite_i, ALUSrc_i, MemWrite_i, MemRead_i and MemtoReg_i, input, 1 bit each: the control fields.
REQ-015 The block SHALL have port ALUOp_i, input, ALUOP_W bits: the ALU opcode.
REQ-016 The block SHALL have, for every field input listed in REQ-010 to REQ-015, a same-width output with the _o suffix: the registered copy of that field.
REQ-017 The block SHALL have port load_use_o, output, 1 bit: a load-use hazard is detected against the decode stage.
REQ-018 The block SHALL have ports stall_cnt_o and bubble_cnt_o, output, CNT_W bits each: the performance counters.

Function
REQ-019 Each falling edge SHALL apply one action, chosen by priority: reset, then flush, then stall, then load.
REQ-020 Load (stall_i=0, flush_i=0): all _o fields SHALL capture their _i values, giving 1-cycle latency.
REQ-021 Stall (stall_i=1, flush_i=0): all _o fields SHALL hold their values unchanged.
REQ-022 Flush (flush_i=1, stall_i ignored): valid_o, every 1-bit control output and ALUOp_o SHALL become 0.
REQ-023 Flush: address and data fields SHALL capture their _i values, keeping the datapath deterministic.
REQ-024 Control outputs SHALL be gated: when valid_i=0 on a load, every control output and ALUOp_o SHALL be loaded as 0.
REQ-025 load_use_o SHALL be combinational and equal 1 iff valid_o=1, MemRead_o=1, Wreg_addr_o≠0, and Wreg_addr_o equals Rreg_addr1_i or Rreg_addr2_i.
REQ-026 load_use_o SHALL NOT drive stall_i internally; the hazard unit closes that loop.
REQ-027 stall_cnt_o SHALL increment by 1 on each edge where stall_i=1, flush_i=0 and valid_o=1.
REQ-028 bubble_cnt_o SHALL increment by 1 on each edge where flush_i=1.
REQ-029 Both counters SHALL saturate at 2^CNT_W−1 and never wrap.
REQ-030 cnt_clr_i=1 SHALL zero both counters; it has priority over an increment on the same edge.
REQ-031 cnt_clr_i SHALL NOT affect the pipeline fields.
REQ-032 The block SHALL have no combinational path from any _i field input to any _o field output.

Reset
REQ-033 When RSTn=0 at a falling edge, every _o field, stall_cnt_o and bubble_cnt_o SHALL become 0.
REQ-034 During reset, reset SHALL override stall_i, flush_i and cnt_clr_i.
REQ-035 Reset asserted mid-stall SHALL discard the held instruction; the first edge with RSTn=1 SHALL perform a normal prioritised action.
REQ-036 Before the first reset edge, outputs are undefined; the bench SHALL NOT check them.

Verification
REQ-037 Load: reset, then load valid_i=1, Rdata1_i=0x1234_5678, ALUOp_i=4'h2, RegWrite_i=1 -> next edge Rdata1_o=0x1234_5678, ALUOp_o=2, RegWrite_o=1, valid_o=1.
REQ-038 Stall and flush: after REQ-037, hold stall_i=1 for 3 edges with new inputs, then flush_i=1 and stall_i=1 on one edge -> outputs hold for 3 edges and stall_cnt_o=3; after the flush edge valid_o=0, all control outputs 0, and bubble_cnt_o=1.
REQ-039 Load-use: load MemRead_i=1, Wreg_addr_i=5'd8, valid_i=1, then drive Rreg_addr2_i=8 -> load_use_o=1; with Wreg_addr_i=0 instead -> load_use_o=0.
REQ-040 Invalid gating: load valid_i=0 with all control inputs 1 -> all control outputs 0 and data fields equal their inputs.
REQ-041 Saturation and clear: CNT_W=4, stall for 20 edges -> stall_cnt_o=15; cnt_clr_i=1 on an edge with stall_i=1 -> stall_cnt_o=0.
REQ-042 Reset mid-stall: stall with valid_o=1, then RSTn=0 for one edge -> all outputs 0; on release with stall_i=1, outputs stay 0.
